// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS memory arbiter.
package mips_mem_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;
    localparam int NPORT      = 3;

    localparam logic [1:0] PORT_LD = 2'd0;
    localparam logic [1:0] PORT_DM = 2'd1;
    localparam logic [1:0] PORT_IF = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_HALT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mips_arb_pick.sv
// Fixed-priority pick (ld > dm > if) over eligible requests; fetch_first_i
// lets a starved fetch jump ahead of the data port, never the loader.
module mips_arb_pick
    import mips_mem_pkg::*;
(
    input  logic [NPORT-1:0] req_i,
    input  logic [NPORT-1:0] elig_i,
    input  logic             fetch_first_i,
    output logic             valid_o,
    output logic [1:0]       idx_o
);

    logic [NPORT-1:0] cand;

    always_comb begin
        cand    = req_i & elig_i;
        valid_o = |cand;
        idx_o   = PORT_LD;
        if (cand[PORT_LD])                       idx_o = PORT_LD;
        else if (fetch_first_i && cand[PORT_IF]) idx_o = PORT_IF;
        else if (cand[PORT_DM])                  idx_o = PORT_DM;
        else if (cand[PORT_IF])                  idx_o = PORT_IF;
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Three-port (loader / MEM / IF) arbiter in front of a synchronous word RAM.
// Optional fetch-starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halted,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [31:0]       ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    // state | meaning
    // RUN   | normal operation, all three ports eligible
    // LOAD  | program loader owns memory, only ld eligible
    // HALT  | processor halted, fetch masked, ld and dm eligible
    arb_state_e state_q, state_d;

    logic [NPORT-1:0]  req_v, elig, gnt_q, gnt_d, rvalid_q, rvalid_d;
    logic              init_q, arb_open, pick_valid, fetch_first;
    logic [1:0]        pick_idx;
    logic              sel_we, sel_oor, ld_rd_out;
    logic [31:0]       sel_addr;
    logic [DATA_W-1:0] sel_wdata, ret_data;
    logic              rd_q, rd_d, err_q, err_d, rzero_q;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    assign req_v = {if_req, dm_req, ld_req};

    // A grant cycle is an arbitration bubble; init_q keeps the first edge after reset grant-free.
    assign arb_open  = init_q & ~|gnt_q;
    assign ld_rd_out = gnt_q[PORT_LD] & rd_q;

    mips_arb_pick u_pick (
        .req_i         (req_v),
        .elig_i        (elig & {NPORT{arb_open}}),
        .fetch_first_i (fetch_first),
        .valid_o       (pick_valid),
        .idx_o         (pick_idx)
    );

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0] starve_q, starve_d;

    always_comb begin
        starve_d = starve_q;
        if (gnt_q[PORT_IF])
            starve_d = '0;
        else if (state_q == ST_RUN && if_req && starve_q != STARVE_LIM)
            starve_d = starve_q + SW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_q <= '0;
        else        starve_q <= starve_d;
    end

    assign fetch_first = (starve_q == STARVE_LIM);
`else
    // Strict priority; STARVE_MAX only has meaning with the guard built in.
    assign fetch_first = (STARVE_MAX < 0);
`endif

    always_comb begin
        sel_we    = ld_we;
        sel_addr  = ld_addr;
        sel_wdata = ld_wdata;
        case (pick_idx)
            PORT_DM: begin
                sel_we    = dm_we;
                sel_addr  = dm_addr;
                sel_wdata = dm_wdata;
            end
            PORT_IF: begin
                sel_we    = 1'b0;
                sel_addr  = if_addr;
                sel_wdata = '0;
            end
            default: ;
        endcase
        sel_oor     = |sel_addr[31:ADDR_W];
        gnt_d       = '0;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        err_d       = 1'b0;
        rd_d        = 1'b0;
        if (pick_valid) begin
            gnt_d       = NPORT'(1) << pick_idx;
            mem_en_d    = ~sel_oor;
            mem_we_d    = sel_we & ~sel_oor;
            mem_addr_d  = sel_addr[ADDR_W-1:0];
            mem_wdata_d = sel_we ? sel_wdata : '0;
            err_d       = sel_oor;
            rd_d        = ~sel_we;
        end
        rvalid_d = rd_q ? gnt_q : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q      <= 1'b0;
            gnt_q       <= '0;
            rvalid_q    <= '0;
            rd_q        <= 1'b0;
            err_q       <= 1'b0;
            rzero_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            init_q      <= 1'b1;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rd_q        <= rd_d;
            err_q       <= err_d;
            rzero_q     <= err_q;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (ld_req)      state_d = ST_LOAD;
                else if (halted) state_d = ST_HALT;
            end
            ST_LOAD: begin
                if (!ld_req && !ld_rd_out) state_d = halted ? ST_HALT : ST_RUN;
            end
            ST_HALT: begin
                if (ld_req)       state_d = ST_LOAD;
                else if (!halted) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        elig = '0;
        case (state_q)
            ST_RUN:  elig = '1;
            ST_LOAD: elig[PORT_LD] = 1'b1;
            ST_HALT: begin
                elig[PORT_LD] = 1'b1;
                elig[PORT_DM] = 1'b1;
            end
            default: elig = '0;
        endcase
    end

    // Out-of-range reads return zero rather than whatever the RAM last drove.
    assign ret_data  = rzero_q ? '0 : mem_rdata;

    assign ld_gnt    = gnt_q[PORT_LD];
    assign dm_gnt    = gnt_q[PORT_DM];
    assign if_gnt    = gnt_q[PORT_IF];
    assign ld_rvalid = rvalid_q[PORT_LD];
    assign dm_rvalid = rvalid_q[PORT_DM];
    assign if_rvalid = rvalid_q[PORT_IF];
    assign ld_rdata  = rvalid_q[PORT_LD] ? ret_data : '0;
    assign dm_rdata  = rvalid_q[PORT_DM] ? ret_data : '0;
    assign if_rdata  = rvalid_q[PORT_IF] ? ret_data : '0;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: vector table plus multi-cycle sequences.
module tb_mips_mem_arbiter;
    import mips_mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halted = 1'b0;
    logic        ld_req = 1'b0, ld_we = 1'b0;
    logic [31:0] ld_addr = '0, ld_wdata = '0;
    logic        dm_req = 1'b0, dm_we = 1'b0;
    logic [31:0] dm_addr = '0, dm_wdata = '0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        ld_gnt, ld_rvalid, dm_gnt, dm_rvalid, if_gnt, if_rvalid;
    logic [31:0] ld_rdata, dm_rdata, if_rdata;
    logic        mem_en, mem_we, err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] ram [0:1023] = '{0: 32'h2801000a, default: 32'h0};

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    mips_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .halted(halted),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .if_req(if_req), .if_addr(if_addr),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .err(err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] p, input logic req, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        case (p)
            PORT_LD: begin ld_req = req; ld_we = we; ld_addr = a; ld_wdata = d; end
            PORT_DM: begin dm_req = req; dm_we = we; dm_addr = a; dm_wdata = d; end
            default: begin if_req = req; if_addr = a; end
        endcase
    endtask

    function automatic logic [2:0] gnt_vec();
        return {if_gnt, dm_gnt, ld_gnt};
    endfunction

    function automatic logic [2:0] rv_vec();
        return {if_rvalid, dm_rvalid, ld_rvalid};
    endfunction

    function automatic logic [31:0] rdata_of(input logic [1:0] p);
        case (p)
            PORT_LD: return ld_rdata;
            PORT_DM: return dm_rdata;
            default: return if_rdata;
        endcase
    endfunction

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctl"}, {gnt_vec(), rv_vec(), mem_en, mem_we, err}, 32'h0);
        chk({nm, "_addr"}, {22'h0, mem_addr}, 32'h0);
        chk({nm, "_wdata"}, mem_wdata, 32'h0);
        chk({nm, "_rdata"}, ld_rdata | dm_rdata | if_rdata, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t        vt [11];
    logic [31:0] ldw [9];
    logic [2:0]  oh;
    bit          got;

    initial begin
        vt[0]  = '{PORT_IF, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h2801000a};
        vt[1]  = '{PORT_DM, 1'b1, 32'h0000_0005, 32'hdeadbeef,  1'b0, 32'h0};
        vt[2]  = '{PORT_DM, 1'b0, 32'h0000_0005, 32'h0,         1'b0, 32'hdeadbeef};
        vt[3]  = '{PORT_LD, 1'b1, 32'h0000_03ff, 32'h12345678,  1'b0, 32'h0};
        vt[4]  = '{PORT_IF, 1'b0, 32'h0000_03ff, 32'h0,         1'b0, 32'h12345678};
        vt[5]  = '{PORT_DM, 1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0};
        vt[6]  = '{PORT_LD, 1'b0, 32'h8000_0000, 32'h0,         1'b1, 32'h0};
        vt[7]  = '{PORT_DM, 1'b1, 32'h0000_0400, 32'hcafef00d,  1'b1, 32'h0};
        vt[8]  = '{PORT_IF, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h2801000a};
        vt[9]  = '{PORT_LD, 1'b0, 32'h0000_0005, 32'h0,         1'b0, 32'hdeadbeef};
        vt[10] = '{PORT_IF, 1'b0, 32'h0000_0800, 32'h0,         1'b1, 32'h0};
        for (int i = 0; i < 8; i++) ldw[i] = 32'h3c01_0010 + 32'(i);
        ldw[8] = 32'hfc000000;

        // Reset state
        #12;
        chk_all_zero("reset");
        #10 rst_n = 1'b1;
        tick();
        chk_all_zero("post_reset_idle");

        // Single-transaction vectors
        for (int i = 0; i < 11; i++) begin
            oh = 3'(1 << vt[i].port);
            drive(vt[i].port, 1'b1, vt[i].we, vt[i].addr, vt[i].wdata);
            tick();
            chk($sformatf("v%0d_gnt", i), gnt_vec(), oh);
            chk($sformatf("v%0d_mem_en", i), mem_en, !vt[i].err);
            chk($sformatf("v%0d_mem_we", i), mem_we, vt[i].we & !vt[i].err);
            if (!vt[i].err) chk($sformatf("v%0d_mem_addr", i), mem_addr, vt[i].addr[9:0]);
            chk($sformatf("v%0d_err", i), err, vt[i].err);
            chk($sformatf("v%0d_rv_early", i), rv_vec(), 3'b000);
            drive(vt[i].port, 1'b0, 1'b0, 32'h0, 32'h0);
            tick();
            chk($sformatf("v%0d_rvalid", i), rv_vec(), vt[i].we ? 3'b000 : oh);
            chk($sformatf("v%0d_rdata", i), rdata_of(vt[i].port), vt[i].rdata);
            chk($sformatf("v%0d_idle", i), {gnt_vec(), err}, 4'h0);
            tick();
        end

        // dm and if held together for six cycles
        drive(PORT_DM, 1'b1, 1'b0, 32'h5, 32'h0);
        drive(PORT_IF, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int c = 1; c <= 6; c++) begin
            tick();
`ifdef MEM_ARB_STARVE_GUARD_EN
            chk($sformatf("starve_dm_c%0d", c), dm_gnt, (c == 1 || c == 3));
            chk($sformatf("starve_if_c%0d", c), if_gnt, (c == 5));
`else
            chk($sformatf("starve_dm_c%0d", c), dm_gnt, c % 2);
            chk($sformatf("starve_if_c%0d", c), if_gnt, 1'b0);
`endif
        end
        drive(PORT_DM, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(PORT_IF, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) tick();

        // Loader burst of nine words with fetch and data requests pending
        drive(PORT_IF, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(PORT_DM, 1'b1, 1'b0, 32'h6, 32'h0);
        for (int w = 0; w < 9; w++) begin
            drive(PORT_LD, 1'b1, 1'b1, 32'(w), ldw[w]);
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                tick();
                chk($sformatf("load_w%0d_no_if", w), if_gnt, 1'b0);
                chk($sformatf("load_w%0d_no_dm", w), dm_gnt, 1'b0);
                if (ld_gnt) got = 1'b1;
            end
            if (!got) chk($sformatf("load_w%0d_gnt_timeout", w), 32'h0, 32'h1);
        end
        drive(PORT_LD, 1'b0, 1'b0, 32'h0, 32'h0);
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            tick();
            if (dm_gnt) got = 1'b1;
            else chk("load_if_before_dm", if_gnt, 1'b0);
        end
        chk("load_dm_after_drop", got, 1'b1);
        drive(PORT_DM, 1'b0, 1'b0, 32'h0, 32'h0);
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            tick();
            if (if_gnt) got = 1'b1;
        end
        chk("load_if_after_drop", got, 1'b1);
        drive(PORT_IF, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("load_if_rvalid", if_rvalid, 1'b1);
        chk("load_if_rdata", if_rdata, ldw[0]);
        chk("load_ram8", ram[8], 32'hfc000000);
        chk("load_ram3", ram[3], ldw[3]);
        repeat (2) tick();

        // Halted: fetch masked, data port still served
        halted = 1'b1;
        tick();
        drive(PORT_DM, 1'b1, 1'b0, 32'h6, 32'h0);
        drive(PORT_IF, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk($sformatf("halt_if_c%0d", c), if_gnt, 1'b0);
            chk($sformatf("halt_dm_c%0d", c), dm_gnt, c % 2);
        end
        halted = 1'b0;
        drive(PORT_DM, 1'b0, 1'b0, 32'h0, 32'h0);
        got = 1'b0;
        for (int c = 0; c < 6 && !got; c++) begin
            tick();
            if (if_gnt) got = 1'b1;
        end
        chk("halt_if_after_release", got, 1'b1);
        drive(PORT_IF, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) tick();

        // Reset right after an if_gnt read: the read must be dropped
        drive(PORT_IF, 1'b1, 1'b0, 32'h0, 32'h0);
        tick();
        chk("rst_if_gnt", if_gnt, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        tick();
        chk_all_zero("rst_hold");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_no_gnt_edge1", gnt_vec(), 3'b000);
        chk("rst_no_rvalid_edge1", rv_vec(), 3'b000);
        got = 1'b0;
        for (int c = 0; c < 4 && !got; c++) begin
            tick();
            if (if_gnt) got = 1'b1;
            else chk("rst_no_rvalid_wait", rv_vec(), 3'b000);
        end
        chk("rst_if_regrant", got, 1'b1);
        drive(PORT_IF, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        chk("rst_if_rvalid", if_rvalid, 1'b1);
        chk("rst_if_rdata", if_rdata, ldw[0]);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
